// File: rtl/dvb_s2_bch_pkg.sv
// Shared constants and FSM encoding for the DVB-S2 normal-frame t=10 BCH encoder.
package dvb_s2_bch_pkg;
    localparam int W           = 20;
    localparam int P_WORDS     = 8;
    localparam int PAR_LEN     = 160;
    localparam int K_WORDS_R23 = 2152;
    localparam int K_WORDS_R56 = 2692;
    localparam int CNT_W       = 12;
    localparam int ROW_W       = 5;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_FOLD = 2'd1,
        S_PAR  = 2'd2
    } bch_state_t;
endpackage

// File: rtl/dvb_s2_bch_t10_enc_core.sv
// 20-bit-parallel systematic BCH encoder: folds ROM rows into a 160-bit remainder.
// Optional build macro DVB_S2_BCH_BYPASS_EN adds a per-frame bch_bypass input.
module dvb_s2_bch_t10_enc_core
    import dvb_s2_bch_pkg::*;
#(
    parameter int K_WORDS = K_WORDS_R23
) (
    input  logic               clk_1x,
    input  logic               rst_n,
    input  logic [W-1:0]       s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [W-1:0]       m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               rom_rd_en,
    output logic [ROW_W-1:0]   rom_rdaddr,
    input  logic [PAR_LEN-1:0] rom_rd_q,
    output logic               err_len,
`ifdef DVB_S2_BCH_BYPASS_EN
    input  logic               bch_bypass,
`endif
    output logic [1:0]         state_dbg
);
    // Handshakes: a word moves on a rising clk_1x edge where valid & ready are both 1;
    // valid never waits on ready, and data/last stay stable while valid & ~ready.
    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K_WORDS);

    bch_state_t         state, state_nxt;
    logic [PAR_LEN-1:0] r;
    logic [W-1:0]       fb;
    logic [ROW_W-1:0]   fold_cyc;
    logic [ROW_W-1:0]   k;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [3:0]         par_cnt;
    logic               last_lat;
    logic               accept;
    logic               at_k;
    logic               out_free;
    logic               byp_now;

`ifdef DVB_S2_BCH_BYPASS_EN
    logic byp_lat;
    // Mode is taken from the first word of a frame and held until it ends.
    assign byp_now = (word_cnt == '0) ? bch_bypass : byp_lat;

    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n)                        byp_lat <= 1'b0;
        else if (accept && word_cnt == '0) byp_lat <= bch_bypass;
    end
`else
    assign byp_now = 1'b0;
`endif

    assign accept    = s_valid & s_ready;
    assign cnt_nxt   = word_cnt + 1'b1;
    assign at_k      = (cnt_nxt == K_CNT);
    assign out_free  = ~m_valid | m_ready;
    assign state_dbg = state;

    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        rom_rd_en  = 1'b0;
        rom_rdaddr = '0;
        case (state)
            S_WAIT: begin
                s_ready = out_free;
                if (s_valid && out_free && !byp_now) state_nxt = S_FOLD;
            end
            S_FOLD: begin
                if (fold_cyc < ROW_W'(W)) begin
                    rom_rd_en  = 1'b1;
                    rom_rdaddr = fold_cyc;
                end
                if (fold_cyc == ROW_W'(W)) state_nxt = last_lat ? S_PAR : S_WAIT;
            end
            S_PAR: begin
                if (par_cnt == 4'(P_WORDS) && m_ready) state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            r        <= '0;
            fb       <= '0;
            fold_cyc <= '0;
            k        <= '0;
            word_cnt <= '0;
            par_cnt  <= '0;
            last_lat <= 1'b0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (accept) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        if (byp_now) begin
                            m_last   <= s_last;
                            word_cnt <= s_last ? '0 : cnt_nxt;
                        end else begin
                            m_last   <= 1'b0;
                            fb       <= r[PAR_LEN-1 -: W] ^ s_data;
                            r        <= {r[PAR_LEN-W-1:0], {W{1'b0}}};
                            word_cnt <= cnt_nxt;
                            // Reaching K without s_last also closes the frame.
                            last_lat <= s_last | at_k;
                            err_len  <= ((word_cnt == '0) ? 1'b0 : err_len) | (s_last ^ at_k);
                            k        <= '0;
                            fold_cyc <= '0;
                            par_cnt  <= '0;
                        end
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                end
                S_FOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                    // Row k returns one cycle after its address was issued.
                    if (fold_cyc != '0) begin
                        if (fb[k]) r <= r ^ rom_rd_q;
                        k <= k + 1'b1;
                    end
                    fold_cyc <= fold_cyc + 1'b1;
                end
                S_PAR: begin
                    if (par_cnt == 4'(P_WORDS)) begin
                        if (m_ready) begin
                            m_valid  <= 1'b0;
                            m_last   <= 1'b0;
                            r        <= '0;
                            word_cnt <= '0;
                        end
                    end else if (out_free) begin
                        m_data  <= r[PAR_LEN-1 -: W];
                        m_valid <= 1'b1;
                        m_last  <= (par_cnt == 4'(P_WORDS - 1));
                        r       <= {r[PAR_LEN-W-1:0], {W{1'b0}}};
                        par_cnt <= par_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dvb_s2_bch_t10_enc_core.sv
// Directed bench for the t=10 BCH encoder core with a behavioural ROM and serial-LFSR golden model.
module tb_dvb_s2_bch_t10_enc_core;
  import dvb_s2_bch_pkg::*;

  localparam int KW = 6;

  logic               clk_1x = 1'b0;
  logic               rst_n = 1'b0;
  logic [W-1:0]       s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic               s_ready;
  logic [W-1:0]       m_data;
  logic               m_valid;
  logic               m_last;
  logic               m_ready = 1'b1;
  logic               rom_rd_en;
  logic [ROW_W-1:0]   rom_rdaddr;
  logic [PAR_LEN-1:0] rom_rd_q = '0;
  logic               err_len;
  logic [1:0]         state_dbg;

  int total = 0;
  int bad = 0;

  logic [W:0]         exp_q[$];
  logic [W:0]         got_q[$];
  logic [ROW_W-1:0]   addr_q[$];
  logic [PAR_LEN-1:0] rom [20];
  logic [PAR_LEN-1:0] g_low;
  logic [PAR_LEN-1:0] g_r;
  logic [16:0]        gp [10] = '{17'h1002D, 17'h10173, 17'h10FBD, 17'h15A55, 17'h11F2F,
                                  17'h1F7B5, 17'h1AF65, 17'h17367, 17'h10EA1, 17'h175A7};
  logic [W:0]         held_d;
  logic               held_v = 1'b0;

  dvb_s2_bch_t10_enc_core #(.K_WORDS(KW)) dut (
    .clk_1x(clk_1x), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .rom_rd_en(rom_rd_en), .rom_rdaddr(rom_rdaddr), .rom_rd_q(rom_rd_q),
    .err_len(err_len),
`ifdef DVB_S2_BCH_BYPASS_EN
    .bch_bypass(1'b0),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_1x = ~clk_1x;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // registered ROM, one cycle of latency
  always @(posedge clk_1x) if (rom_rd_en) rom_rd_q <= rom[rom_rdaddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // monitors
  always @(negedge clk_1x) begin
    if (rst_n && m_valid && m_ready) got_q.push_back({m_last, m_data});
    if (rom_rd_en) addr_q.push_back(rom_rdaddr);
    if (rst_n && held_v && m_valid) check("stall_hold", {11'd0, m_last, m_data}, {11'd0, held_d});
    held_v = rst_n && m_valid && !m_ready;
    held_d = {m_last, m_data};
  end

  function automatic logic [PAR_LEN-1:0] lfsr_word(input logic [PAR_LEN-1:0] rin, input logic [W-1:0] d);
    logic [PAR_LEN-1:0] rr;
    logic f;
    rr = rin;
    for (int i = W - 1; i >= 0; i--) begin
      f  = rr[PAR_LEN-1] ^ d[i];
      rr = {rr[PAR_LEN-2:0], 1'b0};
      if (f) rr = rr ^ g_low;
    end
    return rr;
  endfunction

  // driver tasks
  task automatic drive_word(input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    @(negedge clk_1x);
    while (!s_ready && n < 200) begin
      @(negedge clk_1x);
      n++;
    end
    check("s_ready_wait", (n < 200), 1);
    @(posedge clk_1x);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic push_parity(input logic [PAR_LEN-1:0] p);
    for (int i = 0; i < P_WORDS; i++)
      exp_q.push_back({(i == P_WORDS - 1), p[PAR_LEN-1-W*i -: W]});
  endtask

  task automatic drain(input string tag);
    int n;
    int exp_n;
    logic [W:0] e;
    logic [W:0] g;
    n = 0;
    exp_n = exp_q.size();
    while (got_q.size() < exp_n && n < 3000) begin
      @(posedge clk_1x);
      n++;
    end
    repeat (5) @(posedge clk_1x);
    check({tag, "_count"}, got_q.size(), exp_n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      check(tag, {11'd0, g}, {11'd0, e});
    end
    got_q.delete();
    #1;
  endtask

  task automatic random_frame(input logic with_last);
    logic [W-1:0] d;
    g_r = '0;
    for (int w = 0; w < KW; w++) begin
      d = W'($urandom_range(0, 32'hFFFFF));
      g_r = lfsr_word(g_r, d);
      exp_q.push_back({1'b0, d});
      drive_word(d, with_last && (w == KW - 1));
    end
  endtask

  // stimulus and scoreboard
  initial begin
    logic [160:0] a;
    logic [160:0] t;
    logic [ROW_W-1:0] av;
    int n;

    a = 161'd1;
    for (int j = 0; j < 10; j++) begin
      t = '0;
      for (int i = 0; i < 17; i++) if (gp[j][i]) t = t ^ (a << i);
      a = t;
    end
    g_low = a[PAR_LEN-1:0];
    rom[0] = g_low;
    for (int r = 1; r < 20; r++)
      rom[r] = {rom[r-1][PAR_LEN-2:0], 1'b0} ^ (rom[r-1][PAR_LEN-1] ? g_low : '0);

    repeat (3) @(posedge clk_1x);
    #1 rst_n = 1'b1;
    @(negedge clk_1x);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_err_len", err_len, 0);
    check("rst_rom_rd_en", rom_rd_en, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_state", state_dbg, S_WAIT);
    @(posedge clk_1x);
    #1;

    // single word 0x00001 with s_last: early end, parity is ROM row 0
    addr_q.delete();
    exp_q.push_back({1'b0, 20'h00001});
    drive_word(20'h00001, 1'b1);
    push_parity(rom[0]);
    drain("a_out");
    check("a_addr_n", addr_q.size(), 20);
    for (int i = 0; i < 20; i++) begin
      av = (i < addr_q.size()) ? addr_q[i] : 'x;
      check("a_addr", {27'd0, av}, i);
    end
    check("a_err_len", err_len, 1);

    // all-zero frame of KW words
    for (int w = 0; w < KW; w++) begin
      exp_q.push_back('0);
      drive_word('0, (w == KW - 1));
      if (w == 0) check("b_err_clr", err_len, 0);
    end
    push_parity('0);
    drain("b_out");
    check("b_err_len", err_len, 0);

    // random frame with a 1-0-0-1 stall during parity
    random_frame(1'b1);
    n = 0;
    while (got_q.size() < KW + 1 && n < 500) begin
      @(posedge clk_1x);
      n++;
    end
    #1 m_ready = 1'b0;
    repeat (2) @(posedge clk_1x);
    #1 m_ready = 1'b1;
    @(posedge clk_1x);
    #1 m_ready = 1'b0;
    @(posedge clk_1x);
    #1 m_ready = 1'b1;
    push_parity(g_r);
    drain("c_out");
    check("c_err_len", err_len, 0);

    // K words without s_last: frame closes on its own, err_len set
    random_frame(1'b0);
    push_parity(g_r);
    drain("d_out");
    check("d_err_len", err_len, 1);

    // reset at fold cycle 10 of word 3
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back({1'b0, W'(w + 20'h00A5)});
      drive_word(W'(w + 20'h00A5), 1'b0);
    end
    repeat (10) @(posedge clk_1x);
    #1 rst_n = 1'b0;
    #1;
    check("e_m_valid", m_valid, 0);
    check("e_rom_rd_en", rom_rd_en, 0);
    check("e_state", state_dbg, S_WAIT);
    check("e_err_len", err_len, 0);
    repeat (2) @(posedge clk_1x);
    #1 rst_n = 1'b1;
    drain("e_out");

    random_frame(1'b1);
    push_parity(g_r);
    drain("f_out");
    check("f_err_len", err_len, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
